// File: rtl/mixer_pkg.sv
// Shared constants and width helpers for the N-channel sound mixer.
package mixer_pkg;

  localparam logic [7:0] OFS_CHSEL = 8'd0;
  localparam logic [7:0] OFS_VOL   = 8'd1;
  localparam logic [7:0] OFS_MUTE  = 8'd2;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int prod_w(input int in_w, input int vol_w);
    return in_w + vol_w;
  endfunction

  // Wide enough for NUM_CH full-scale products, so the frame sum never wraps.
  function automatic int sum_w(input int in_w, input int vol_w, input int n);
    return in_w + vol_w + clog2(n);
  endfunction

endpackage

// File: rtl/mixer_ndac_sd.sv
// First-order sigma-delta modulator: the carry of a running sum is the bitstream.
module sigma_delta_dac #(
  parameter int SW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [SW-1:0] sample,
  output logic          audio_out
);

  logic [SW-1:0] sd_acc;
  logic [SW:0]   sum;

  assign sum = {1'b0, sd_acc} + {1'b0, sample};

  always_ff @(posedge clk) begin
    if (reset) begin
      sd_acc    <= '0;
      audio_out <= 1'b0;
    end else begin
      sd_acc    <= sum[SW-1:0];
      audio_out <= sum[SW];
    end
  end

endmodule

// File: rtl/mixer_ndac.sv
// N-channel time-multiplexed mixer with per-channel volume and a 1-bit DAC.
// Optional mute mask register at REG_BASE+2 is built when MIXER_MUTE_EN is defined.
module mixer_ndac
  import mixer_pkg::*;
#(
  parameter int         NUM_CH   = 4,
  parameter int         IN_W     = 8,
  parameter int         VOL_W    = 4,
  parameter logic [7:0] REG_BASE = 8'hF8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             zxuno_addr,
  input  logic                   zxuno_regrd,
  input  logic                   zxuno_regwr,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   oe_n,
  input  logic [NUM_CH*IN_W-1:0] ch_in,
  output logic                   sample_strobe,
  output logic                   audio_out
);

  localparam int CW = clog2(NUM_CH);
  localparam int PW = prod_w(IN_W, VOL_W);
  localparam int SW = sum_w(IN_W, VOL_W, NUM_CH);

  localparam logic [7:0]    A_CHSEL = REG_BASE + OFS_CHSEL;
  localparam logic [7:0]    A_VOL   = REG_BASE + OFS_VOL;
  localparam logic [7:0]    A_MUTE  = REG_BASE + OFS_MUTE;
  localparam logic [CW-1:0] LAST    = CW'(NUM_CH - 1);
  localparam logic [4:0]    NCH5    = 5'(NUM_CH);

  logic [3:0]                   chsel;
  logic [NUM_CH-1:0][VOL_W-1:0] vol;
  logic [NUM_CH-1:0][IN_W-1:0]  ch_arr;
  logic [VOL_W-1:0]             vol_rd;
  logic                         chsel_ok;
  logic                         wr_chsel, wr_vol;
  logic                         unused_din;

  logic [CW-1:0]                slot;
  logic [PW-1:0]                prod;
  logic [SW-1:0]                acc, acc_next, sample;
  logic [1:0]                   vld_pipe;

  assign ch_arr     = ch_in;
  assign chsel_ok   = {1'b0, chsel} < NCH5;
  assign wr_chsel   = zxuno_regwr && (zxuno_addr == A_CHSEL);
  assign wr_vol     = zxuno_regwr && (zxuno_addr == A_VOL) && chsel_ok;
  assign unused_din = ^din;

`ifdef MIXER_MUTE_EN
  logic [NUM_CH-1:0] mute;
  logic              wr_mute;

  assign wr_mute = zxuno_regwr && (zxuno_addr == A_MUTE);

  always_ff @(posedge clk) begin
    if (reset)        mute <= '0;
    else if (wr_mute) mute <= NUM_CH'(din);
  end
`endif

  // Register bank
  always_ff @(posedge clk) begin
    if (reset) begin
      chsel <= '0;
      vol   <= '1;
    end else begin
      if (wr_chsel) chsel <= din[3:0];
      for (int k = 0; k < NUM_CH; k++)
        if (wr_vol && chsel == 4'(k)) vol[k] <= din[VOL_W-1:0];
    end
  end

  always_comb begin
    vol_rd = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (chsel == 4'(k)) vol_rd = vol[k];
  end

  // Reads see the registers before any same-cycle write lands.
  always_comb begin
    dout = '0;
    oe_n = 1'b1;
    if (zxuno_regrd) begin
      case (zxuno_addr)
        A_CHSEL: begin dout = {4'b0, chsel}; oe_n = 1'b0; end
        A_VOL:   begin dout = 8'(vol_rd);    oe_n = 1'b0; end
`ifdef MIXER_MUTE_EN
        A_MUTE:  begin dout = 8'(mute);      oe_n = 1'b0; end
`endif
        default: ;
      endcase
    end
  end

  // Sequencer: one channel multiply-accumulate per clock
  always_comb begin
    prod = PW'(ch_arr[slot]) * PW'(vol[slot]);
`ifdef MIXER_MUTE_EN
    if (mute[slot]) prod = '0;
`endif
    acc_next = acc + SW'(prod);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot     <= '0;
      acc      <= '0;
      sample   <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], slot == LAST};
      if (slot == LAST) begin
        slot   <= '0;
        sample <= acc_next;
        acc    <= '0;
      end else begin
        slot <= slot + CW'(1);
        acc  <= acc_next;
      end
    end
  end

  // Strobe trails the sample latch by one cycle so the sample is settled when seen.
  assign sample_strobe = vld_pipe[1];

  sigma_delta_dac #(.SW(SW)) u_sd (
    .clk       (clk),
    .reset     (reset),
    .sample    (sample),
    .audio_out (audio_out)
  );

endmodule

// File: tb/tb_mixer_ndac.sv
// Directed bench for mixer_ndac at NUM_CH=4, IN_W=8, VOL_W=4 (SW=14).
module tb_mixer_ndac;

  localparam logic [7:0] RB = 8'hF8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  zxuno_addr = 8'h00;
  logic        zxuno_regrd = 1'b0;
  logic        zxuno_regwr = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        oe_n;
  logic [31:0] ch_in = 32'hFFFF_FFFF;
  logic        sample_strobe;
  logic        audio_out;

  int n_checks = 0;
  int n_err    = 0;

  mixer_ndac #(.NUM_CH(4), .IN_W(8), .VOL_W(4), .REG_BASE(RB)) dut (
    .clk           (clk),
    .reset         (reset),
    .zxuno_addr    (zxuno_addr),
    .zxuno_regrd   (zxuno_regrd),
    .zxuno_regwr   (zxuno_regwr),
    .din           (din),
    .dout          (dout),
    .oe_n          (oe_n),
    .ch_in         (ch_in),
    .sample_strobe (sample_strobe),
    .audio_out     (audio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    zxuno_addr  = a;
    din         = d;
    zxuno_regwr = 1'b1;
    @(negedge clk);
    zxuno_regwr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
    @(negedge clk);
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    #1;
    d  = dout;
    oe = oe_n;
    zxuno_regrd = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sample_strobe) begin seen = 1'b1; break; end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [7:0] d;
    logic       oe;
    int         ones;
    int         gap;
    int         first;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_audio", 32'(audio_out), 32'd0);
    chk("rst_strobe", 32'(sample_strobe), 32'd0);
    chk("rst_sample", 32'(dut.sample), 32'd0);
    for (int k = 0; k < 4; k++) begin
      wr(RB, 8'(k));
      rd(RB + 8'd1, d, oe);
      chk($sformatf("rst_vol%0d", k), 32'(d), 32'h0F);
      chk($sformatf("rst_vol_oe%0d", k), 32'(oe), 32'd0);
    end

    // Full scale, default volumes
    wait_strobe("fs_strobe");
    chk("fs_sample", 32'(dut.sample), 32'd15300);
    gap = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      gap++;
      if (sample_strobe) break;
    end
    chk("fs_period", 32'(gap), 32'd4);
    chk("fs_sample2", 32'(dut.sample), 32'd15300);
    ones = 0;
    repeat (16384) begin
      @(posedge clk); #1;
      ones += int'(audio_out);
    end
    chk("fs_density", 32'((ones >= 15299 && ones <= 15301) ? 1 : 0), 32'd1);

    // Channel 2 alone, volume 0 then 8
    wr(RB, 8'd2);
    wr(RB + 8'd1, 8'd0);
    ch_in = 32'h0080_0000;
    wait_strobe("v0_strobe_a");
    wait_strobe("v0_strobe_b");
    chk("v0_sample", 32'(dut.sample), 32'd0);
    ones = 0;
    repeat (64) begin
      @(posedge clk); #1;
      ones += int'(audio_out);
    end
    chk("v0_audio_silent", 32'(ones), 32'd0);
    wr(RB + 8'd1, 8'd8);
    wait_strobe("v8_strobe_a");
    wait_strobe("v8_strobe_b");
    chk("v8_sample", 32'(dut.sample), 32'd1024);

    // Out-of-range chsel: volume write dropped, read returns 0
    wr(RB, 8'd5);
    wr(RB + 8'd1, 8'd3);
    rd(RB + 8'd1, d, oe);
    chk("oor_vol_rd", 32'(d), 32'd0);
    rd(RB, d, oe);
    chk("oor_chsel_rd", 32'(d), 32'd5);
    for (int k = 0; k < 4; k++) begin
      wr(RB, 8'(k));
      rd(RB + 8'd1, d, oe);
      chk($sformatf("oor_keep_vol%0d", k), 32'(d), (k == 2) ? 32'h08 : 32'h0F);
    end

    // Read and write of the same register in one cycle
    wr(RB, 8'd0);
    @(negedge clk);
    zxuno_addr  = RB + 8'd1;
    din         = 8'h04;
    zxuno_regrd = 1'b1;
    zxuno_regwr = 1'b1;
    #1;
    chk("rdwr_old", 32'(dout), 32'h0F);
    chk("rdwr_oe", 32'(oe_n), 32'd0);
    @(posedge clk); #1;
    zxuno_regwr = 1'b0;
    #1;
    chk("rdwr_new", 32'(dout), 32'h04);
    zxuno_regrd = 1'b0;

    // Reset landing on slot 2; frame restarts at slot 0
    wait_strobe("mid_rst_sync");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_sample", 32'(dut.sample), 32'd0);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (sample_strobe) begin first = i; break; end
    end
    chk("mid_rst_strobe_at", 32'(first), 32'd5);

    // Mute mask register
    ch_in = 32'hFFFF_FFFF;
`ifdef MIXER_MUTE_EN
    wr(RB + 8'd2, 8'h05);
    rd(RB + 8'd2, d, oe);
    chk("mute_rd", 32'(d), 32'h05);
    chk("mute_oe", 32'(oe), 32'd0);
    wait_strobe("mute_strobe_a");
    wait_strobe("mute_strobe_b");
    chk("mute_sample", 32'(dut.sample), 32'd7650);
`else
    rd(RB + 8'd2, d, oe);
    chk("nomute_oe", 32'(oe), 32'd1);
    wr(RB + 8'd2, 8'h05);
    rd(RB, d, oe);
    chk("nomute_chsel", 32'(d), 32'd0);
    wait_strobe("nomute_strobe_a");
    wait_strobe("nomute_strobe_b");
    chk("nomute_sample", 32'(dut.sample), 32'd15300);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
